// File: rtl/score_ram_ctrl_if.sv
// Score RAM bus between the controller and a synchronous single-port RAM.
// Master drives address/write side; slave returns read data.
interface score_ram_ctrl_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      output ram_addr,
      output ram_we,
      output ram_wdata,
      input  ram_rdata
   );

   modport slave (
      input  ram_addr,
      input  ram_we,
      input  ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/score_ram_ctrl.sv
// Score-table controller: per-player best, global high, dump and clear.
// Player slots at 0..NUM_USERS-1, high slot at NUM_USERS.
module score_ram_ctrl #(
   parameter int DATA_W    = 8,
   parameter int NUM_USERS = 6,
   parameter int ADDR_W    = 3,
   parameter int RD_LAT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              game_over,
   input  logic [ADDR_W-1:0] user_id,
   input  logic [DATA_W-1:0] score_in,
   input  logic              dump_req,
   input  logic              clear_req,
   score_ram_ctrl_if.master  bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              new_user_best,
   output logic              new_high,
   output logic [DATA_W-1:0] high_score,
   output logic [ADDR_W-1:0] high_user,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_done
);

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CW-1:0] LAST = CW'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] HI = ADDR_W'(NUM_USERS);

   typedef enum logic [3:0] {
      IDLE, RD_USER, CMP_USER, WR_USER,
      RD_HIGH, CMP_HIGH, WR_HIGH,
      DUMP_RD, DUMP_OUT, CLEAR, DONE
   } state_t;

   state_t state, nxt;

   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] uid_q;
   logic [DATA_W-1:0] score_q;
   logic [DATA_W-1:0] hs_q;
   logic [ADDR_W-1:0] hu_q;
   logic              err_q;
   logic              rd_last;
   logic              uid_ok;

   assign rd_last    = (cnt == LAST);
   assign uid_ok     = (user_id < HI);
   assign high_score = hs_q;
   assign high_user  = hu_q;
   assign err        = err_q;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   // Next state and all state-decoded outputs, incl. the RAM bus.
   always_comb begin
      nxt           = state;
      bus.ram_addr  = '0;
      bus.ram_we    = 1'b0;
      bus.ram_wdata = '0;
      busy          = (state != IDLE);
      done          = 1'b0;
      new_user_best = 1'b0;
      new_high      = 1'b0;
      dump_valid    = 1'b0;
      dump_addr     = '0;
      dump_data     = '0;
      dump_done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear_req)      nxt = CLEAR;
            else if (game_over) nxt = uid_ok ? RD_USER : IDLE;
            else if (dump_req)  nxt = DUMP_RD;
         end
         RD_USER: begin
            bus.ram_addr = uid_q;
            if (rd_last) nxt = CMP_USER;
         end
         CMP_USER: begin
            bus.ram_addr = uid_q;
            nxt = (score_q > bus.ram_rdata) ? WR_USER : DONE;
         end
         WR_USER: begin
            bus.ram_addr  = uid_q;
            bus.ram_we    = 1'b1;
            bus.ram_wdata = score_q;
            new_user_best = 1'b1;
            nxt = RD_HIGH;
         end
         RD_HIGH: begin
            bus.ram_addr = HI;
            if (rd_last) nxt = CMP_HIGH;
         end
         CMP_HIGH: begin
            bus.ram_addr = HI;
            nxt = (score_q > bus.ram_rdata) ? WR_HIGH : DONE;
         end
         WR_HIGH: begin
            bus.ram_addr  = HI;
            bus.ram_we    = 1'b1;
            bus.ram_wdata = score_q;
            new_high      = 1'b1;
            nxt = DONE;
         end
         DUMP_RD: begin
            bus.ram_addr = addr_q;
            if (rd_last) nxt = DUMP_OUT;
         end
         DUMP_OUT: begin
            bus.ram_addr = addr_q;
            dump_valid   = 1'b1;
            dump_addr    = addr_q;
            dump_data    = bus.ram_rdata;
            dump_done    = (addr_q == HI);
            nxt = (addr_q == HI) ? DONE : DUMP_RD;
         end
         CLEAR: begin
            bus.ram_addr = addr_q;
            bus.ram_we   = 1'b1;
            if (addr_q == HI) nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Datapath: request latches, read wait counter, walk address, high copy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         addr_q  <= '0;
         uid_q   <= '0;
         score_q <= '0;
         hs_q    <= '0;
         hu_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (state inside {RD_USER, RD_HIGH, DUMP_RD})
            cnt <= rd_last ? '0 : cnt + 1'b1;
         else
            cnt <= '0;
         unique case (state)
            IDLE: begin
               if (clear_req) begin
                  addr_q <= '0;
                  hs_q   <= '0;
                  hu_q   <= '0;
               end else if (game_over) begin
                  if (uid_ok) begin
                     uid_q   <= user_id;
                     score_q <= score_in;
                  end else begin
                     err_q <= 1'b1;
                  end
               end else if (dump_req) begin
                  addr_q <= '0;
               end
            end
            CMP_HIGH: begin
               if (score_q > bus.ram_rdata) begin
                  hs_q <= score_q;
                  hu_q <= uid_q;
               end
            end
            DUMP_OUT: begin
               if (addr_q == HI) hs_q <= bus.ram_rdata;
               addr_q <= addr_q + 1'b1;
            end
            CLEAR: addr_q <= addr_q + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_score_ram_ctrl.sv
// Directed bench for score_ram_ctrl with a behavioural RD_LAT=2 RAM.
// Table of operations plus hand sequences for dump and mid-op reset.
module tb_score_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       game_over = 1'b0;
   logic [2:0] user_id = '0;
   logic [7:0] score_in = '0;
   logic       dump_req = 1'b0;
   logic       clear_req = 1'b0;
   logic       busy, done, err;
   logic       new_user_best, new_high;
   logic [7:0] high_score;
   logic [2:0] high_user;
   logic       dump_valid, dump_done;
   logic [2:0] dump_addr;
   logic [7:0] dump_data;

   int checks = 0;
   int failures = 0;
   int wd_bad = 0;

   always #5 clk = ~clk;

   score_ram_ctrl_if #(.ADDR_W(3), .DATA_W(8)) bus ();

   score_ram_ctrl #(
      .DATA_W(8), .NUM_USERS(6), .ADDR_W(3), .RD_LAT(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .game_over(game_over),
      .user_id(user_id),
      .score_in(score_in),
      .dump_req(dump_req),
      .clear_req(clear_req),
      .bus(bus),
      .busy(busy),
      .done(done),
      .err(err),
      .new_user_best(new_user_best),
      .new_high(new_high),
      .high_score(high_score),
      .high_user(high_user),
      .dump_valid(dump_valid),
      .dump_addr(dump_addr),
      .dump_data(dump_data),
      .dump_done(dump_done)
   );

   // RAM model: two-cycle read pipeline, preloaded with junk during reset.
   logic [7:0] mem [8];
   logic [7:0] p0, p1;
   assign bus.ram_rdata = p1;

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) mem[i] <= 8'hA0 + 8'(i);
         p0 <= '0;
         p1 <= '0;
      end else begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         p0 <= mem[bus.ram_addr];
         p1 <= p0;
      end
   end

   typedef struct {
      int clr, go, dmp, uid, score;
      int done_k, nwe;
      int fk, fa, fd, lk, la, ld;
      int nub, nh, nerr, hs, hu;
   } vec_t;

   vec_t tbl [10];

   function automatic vec_t mk(
      input int c, g, d, u, s, dk, nw,
      input int fk, fa, fd, lk, la, ld,
      input int nub, nh, ne, hs, hu
   );
      vec_t v;
      v.clr = c; v.go = g; v.dmp = d;
      v.uid = u; v.score = s;
      v.done_k = dk; v.nwe = nw;
      v.fk = fk; v.fa = fa; v.fd = fd;
      v.lk = lk; v.la = la; v.ld = ld;
      v.nub = nub; v.nh = nh; v.nerr = ne;
      v.hs = hs; v.hu = hu;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Issue one request for a cycle, watch up to DONE, check the record.
   task automatic run_op(input int idx, input vec_t v);
      int dk = 0, nwe = 0, nub = 0, nh = 0, ne = 0, bz = 0;
      int fk = 0, fa = 0, fd = 0, lk = 0, la = 0, ld = 0;
      int lim;
      lim = (v.done_k == 0) ? 8 : 40;
      @(negedge clk);
      clear_req = v.clr[0];
      game_over = v.go[0];
      dump_req  = v.dmp[0];
      user_id   = v.uid[2:0];
      score_in  = v.score[7:0];
      for (int k = 1; k <= lim && dk == 0; k++) begin
         @(negedge clk);
         if (bus.ram_we) begin
            nwe++;
            if (nwe == 1) begin
               fk = k;
               fa = int'(bus.ram_addr);
               fd = int'(bus.ram_wdata);
            end
            lk = k;
            la = int'(bus.ram_addr);
            ld = int'(bus.ram_wdata);
         end else if (bus.ram_wdata != 0) begin
            wd_bad++;
         end
         nub += int'(new_user_best);
         nh  += int'(new_high);
         ne  += int'(err);
         bz  += int'(busy);
         if (done) dk = k;
         clear_req = 1'b0;
         game_over = 1'b0;
         dump_req  = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("op%0d done_cycle", idx), dk, v.done_k);
      chk($sformatf("op%0d busy_cycles", idx), bz, v.done_k);
      chk($sformatf("op%0d busy_after", idx), int'(busy), 0);
      chk($sformatf("op%0d we_count", idx), nwe, v.nwe);
      chk($sformatf("op%0d wr0_cycle", idx), fk, v.fk);
      chk($sformatf("op%0d wr0_addr", idx), fa, v.fa);
      chk($sformatf("op%0d wr0_data", idx), fd, v.fd);
      chk($sformatf("op%0d wrN_cycle", idx), lk, v.lk);
      chk($sformatf("op%0d wrN_addr", idx), la, v.la);
      chk($sformatf("op%0d wrN_data", idx), ld, v.ld);
      chk($sformatf("op%0d new_user_best", idx), nub, v.nub);
      chk($sformatf("op%0d new_high", idx), nh, v.nh);
      chk($sformatf("op%0d err", idx), ne, v.nerr);
      chk($sformatf("op%0d high_score", idx), int'(high_score), v.hs);
      chk($sformatf("op%0d high_user", idx), int'(high_user), v.hu);
   endtask

   initial begin
      int exp_d [7];
      int np, dk;
      exp_d = '{0, 8, 5, 0, 0, 0, 8};

      //          c g d u  s    dk nw fk fa fd  lk la ld  ub nh e hs  hu
      tbl[0] = mk(1,0,0,0, 0,   8, 7, 1, 0, 0,  7, 6, 0,  0, 0,0, 0,  0);
      tbl[1] = mk(0,1,0,1, 8,   9, 2, 4, 1, 8,  8, 6, 8,  1, 1,0, 8,  1);
      tbl[2] = mk(0,1,0,1, 8,   4, 0, 0, 0, 0,  0, 0, 0,  0, 0,0, 8,  1);
      tbl[3] = mk(0,1,0,2, 5,   8, 1, 4, 2, 5,  4, 2, 5,  1, 0,0, 8,  1);
      tbl[4] = mk(0,1,0,7, 9,   0, 0, 0, 0, 0,  0, 0, 0,  0, 0,1, 8,  1);
      tbl[5] = mk(0,1,1,6, 50,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,1, 8,  1);
      tbl[6] = mk(0,1,0,0, 200, 9, 2, 4, 0, 200,8, 6, 200,1, 1,0, 200,0);
      tbl[7] = mk(0,1,0,4, 255, 9, 2, 4, 4, 255,8, 6, 255,1, 1,0, 255,4);
      tbl[8] = mk(1,1,0,1, 9,   8, 7, 1, 0, 0,  7, 6, 0,  0, 0,0, 0,  0);
      tbl[9] = mk(0,1,0,5, 1,   9, 2, 4, 5, 1,  8, 6, 1,  1, 1,0, 1,  5);

      repeat (3) @(negedge clk);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst err", int'(err), 0);
      chk("rst ram_we", int'(bus.ram_we), 0);
      chk("rst ram_addr", int'(bus.ram_addr), 0);
      chk("rst ram_wdata", int'(bus.ram_wdata), 0);
      chk("rst flags", int'({new_user_best, new_high}), 0);
      chk("rst high", int'({high_score, high_user}), 0);
      chk("rst dump", int'({dump_valid, dump_done, dump_addr, dump_data}), 0);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) run_op(i, tbl[i]);

      @(negedge clk);
      dump_req = 1'b1;
      np = 0;
      dk = 0;
      for (int k = 1; k <= 40 && dk == 0; k++) begin
         @(negedge clk);
         dump_req = 1'b0;
         if (dump_valid) begin
            if (np < 7) begin
               chk($sformatf("dump%0d cycle", np), k, (np + 1) * 3);
               chk($sformatf("dump%0d addr", np), int'(dump_addr), np);
               chk($sformatf("dump%0d data", np), int'(dump_data), exp_d[np]);
               chk($sformatf("dump%0d last", np), int'(dump_done), int'(np == 6));
            end
            np++;
         end
         if (done) dk = k;
      end
      chk("dump pulses", np, 7);
      chk("dump done_cycle", dk, 22);
      @(negedge clk);
      chk("dump busy_after", int'(busy), 0);
      chk("dump high_score", int'(high_score), 8);

      for (int i = 6; i < 8; i++) run_op(i, tbl[i]);

      @(negedge clk);
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid pre dump_valid", int'(dump_valid), 1);
      chk("mid pre high", int'(high_score), 255);
      #2 rst = 1'b0;
      #1;
      chk("mid busy", int'(busy), 0);
      chk("mid dump_valid", int'(dump_valid), 0);
      chk("mid ram_addr", int'(bus.ram_addr), 0);
      chk("mid high_score", int'(high_score), 0);
      chk("mid high_user", int'(high_user), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("post rst busy", int'(busy), 0);
      chk("post rst dump_valid", int'(dump_valid), 0);

      for (int i = 8; i < 10; i++) run_op(i, tbl[i]);

      chk("wdata zero when idle", wd_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/score_ram_ctrl.md
# score_ram_ctrl

Parametrised score-table controller for the bomb-defuse game. Drives an external synchronous single-port RAM holding one best-score slot per player plus an all-time high-score slot. On game over it performs read-compare-write of the player's best and then the global high. On request it dumps the whole table to the display path or clears it. Sits between the game FSM and the score RAM, with configurable width, player count and RAM read latency.

## Interface
- DATA_W, 8: score width in bits.
- NUM_USERS, 6: player slots, at addresses 0..NUM_USERS-1. The high slot is at address NUM_USERS.
- ADDR_W, 3: RAM address width. Requires 2**ADDR_W >= NUM_USERS+1.
- RD_LAT, 2: RAM read latency in cycles, >= 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- game_over  in  1  request: record score_in for user_id.
- user_id  in  ADDR_W  player index; sampled with game_over.
- score_in  in  DATA_W  final score; sampled with game_over.
- dump_req  in  1  request: read out all NUM_USERS+1 entries.
- clear_req  in  1  request: zero all entries.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  operation in progress; requests are ignored while high.
- done  out  1  one-cycle pulse at the end of every accepted operation.
- err  out  1  one-cycle pulse when game_over carries user_id >= NUM_USERS.
- new_user_best  out  1  one-cycle pulse when a player slot is rewritten.
- new_high  out  1  one-cycle pulse when the high slot is rewritten.
- high_score  out  DATA_W  registered copy of the high slot.
- high_user  out  ADDR_W  player who set high_score.
- dump_valid  out  1  one-cycle strobe; dump_addr and dump_data are valid.
- dump_addr  out  ADDR_W  address being dumped.
- dump_data  out  DATA_W  entry value being dumped.
- dump_done  out  1  coincides with the last dump_valid.

## Operation
- Reset values: all outputs 0. FSM in IDLE. Latched score and ID are 0.
- Request acceptance (IDLE only, level-sampled):
  - Priority is clear_req > game_over > dump_req. Losing requests are dropped, not queued.
  - An invalid user_id produces an err pulse, no RAM access and no done; the FSM stays in IDLE.
- States: IDLE, RD_USER, CMP_USER, WR_USER, RD_HIGH, CMP_HIGH, WR_HIGH, DUMP_RD, DUMP_OUT, CLEAR, DONE.
- Reads:
  - ram_addr is held constant and ram_we=0 from the first read cycle for RD_LAT cycles.
  - ram_rdata is sampled in the following (CMP/OUT) cycle.
  - A wait counter counts RD_LAT.
- Game over:
  - Latch user_id and score_in, then read the player slot.
  - In CMP_USER, the slot is updated only if score > stored (unsigned, strict; ties keep the old value).
  - If no update, go to DONE.
  - Else WR_USER: one cycle with ram_we=1 and new_user_best pulses. Then read the high slot.
  - In CMP_HIGH, if score > stored: WR_HIGH, with new_high pulsing and high_score/high_user loaded. Then DONE.
  - A score that does not beat the player's best never touches the high slot.
- Dump:
  - For each address 0..NUM_USERS: read, then DUMP_OUT pulses dump_valid with the sampled data.
  - When reading address NUM_USERS, high_score is also refreshed from RAM (high_user unchanged).
  - After the last address, go to DONE.
- Clear:
  - Write 0 to addresses 0..NUM_USERS, one per consecutive cycle.
  - high_score and high_user are set to 0. Then DONE.
- DONE: one cycle with done=1 and busy=1; the next cycle is IDLE.
- ram_wdata is 0 whenever ram_we=0.
- Reset mid-operation: all state is cleared immediately and ram_we drops asynchronously. A partially completed clear or dump is not resumed.

## Timing
- Let acceptance be cycle T, and L = RD_LAT.
- busy rises at T+1 and falls the cycle after DONE.
- Game over, full update:
  - RD_USER at T+1; CMP_USER at T+1+L; WR_USER at T+2+L.
  - RD_HIGH at T+3+L; CMP_HIGH at T+3+2L; WR_HIGH at T+4+2L.
  - DONE at T+5+2L.
- Game over, user update only: DONE at T+4+2L.
- Game over, no update: DONE at T+2+L.
- Dump: entry k produces dump_valid at T+(k+1)(L+1); DONE follows the last strobe.
- Clear: ram_we is high from T+1 through T+NUM_USERS+1; DONE at T+NUM_USERS+2.

## Test plan
- Reset, then clear_req (default parameters):
  - ram_we high for 7 cycles at addresses 0..6 with data 0.
  - done at T+8; high_score=0.
- After clear, game_over with user 1, score 8:
  - Writes addr1=8 at T+4 and addr6=8 at T+8.
  - new_user_best and new_high pulse; done at T+9.
  - high_score=8, high_user=1.
- Repeat user 1, score 8 (tie): no ram_we, no flag pulses, done at T+4.
- game_over with user 2, score 5:
  - addr2=5 written; new_user_best only.
  - done at T+8; high_score stays 8.
- dump_req:
  - 7 dump_valid pulses 3 cycles apart, data 0,8,5,0,0,0,8.
  - dump_done on the 7th pulse.
- Edge cases:
  - user_id 7: err pulse, busy stays 0.
  - clear_req and game_over in the same cycle: only the clear executes.
  - rst asserted mid-dump: outputs 0 at once, IDLE after release.
